// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - radix-2 Booth sequential multiplier with start/busy/done handshake
// Optional build macro BOOTH_ZERO_SKIP_EN: zero operand jumps straight to DONE with product 0.
module booth_seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int N  = WIDTH + 1;
   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [N-1:0]  acc;
   logic [N-1:0]  qr;
   logic [N-1:0]  mr;
   logic          q_m1;
   logic [CW-1:0] cnt;

   logic [N-1:0]  acc_sum;
   logic [2*N:0]  shifted;
   logic [N-1:0]  m_ext;
   logic [N-1:0]  q_ext;

   // One extra bit keeps unsigned full-range and the most negative signed value exact.
   assign m_ext = signed_mode ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
   assign q_ext = signed_mode ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};

   always_comb begin
      acc_sum = acc;
      case ({qr[0], q_m1})
         2'b01:   acc_sum = acc + mr;
         2'b10:   acc_sum = acc - mr;
         default: acc_sum = acc;
      endcase
      shifted = {acc_sum[N-1], acc_sum, qr};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         acc     <= '0;
         qr      <= '0;
         mr      <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
`ifdef BOOTH_ZERO_SKIP_EN
                  if (multiplicand == '0 || multiplier == '0) begin
                     product <= '0;
                     state   <= S_DONE;
                  end else begin
                     acc   <= '0;
                     qr    <= q_ext;
                     mr    <= m_ext;
                     q_m1  <= 1'b0;
                     cnt   <= CW'(N);
                     state <= S_RUN;
                  end
`else
                  acc   <= '0;
                  qr    <= q_ext;
                  mr    <= m_ext;
                  q_m1  <= 1'b0;
                  cnt   <= CW'(N);
                  state <= S_RUN;
`endif
               end
            end
            S_RUN: begin
               acc  <= shifted[2*N:N+1];
               qr   <= shifted[N:1];
               q_m1 <= shifted[0];
               cnt  <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  product <= shifted[2*WIDTH:1];
                  state   <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - randomized self-checking bench for booth_seq_mult (WIDTH = 8)
// Honors BOOTH_ZERO_SKIP_EN for expected latency of zero-operand requests.
module tb_booth_seq_mult;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          signed_mode;
   logic [W-1:0]  multiplicand;
   logic [W-1:0]  multiplier;
   logic          busy;
   logic          done;
   logic [2*W-1:0] product;

   int total = 0;
   int bad   = 0;

   booth_seq_mult #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .signed_mode(signed_mode),
      .multiplicand(multiplicand),
      .multiplier(multiplier),
      .busy(busy),
      .done(done),
      .product(product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] ref_mult(input bit sm, input logic [7:0] m, input logic [7:0] q);
      longint a, b, r;
      a = sm ? longint'($signed(m)) : longint'(m);
      b = sm ? longint'($signed(q)) : longint'(q);
      r = a * b;
      return r[15:0];
   endfunction

   function automatic int exp_busy(input logic [7:0] m, input logic [7:0] q);
`ifdef BOOTH_ZERO_SKIP_EN
      if (m == 0 || q == 0) return 0;
`endif
      return W + 1;
   endfunction

   // Wait (bounded) for done after the start-accepting edge, counting busy cycles.
   task automatic wait_done(input string tag, output int bc, output bit seen, input bit scramble);
      bc = 0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            start = 1'b0;
            if (scramble) begin
               multiplicand = W'($urandom);
               multiplier   = W'($urandom);
               signed_mode  = 1'($urandom);
            end
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) bc++;
      end
      check({tag, ".done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic run_op(input string tag, input bit sm, input logic [7:0] m, input logic [7:0] q);
      int bc;
      bit seen;
      logic [15:0] exp;
      exp = ref_mult(sm, m, q);
      @(negedge clk);
      start = 1'b1;
      signed_mode = sm;
      multiplicand = m;
      multiplier = q;
      @(posedge clk);
      wait_done(tag, bc, seen, 1'b1);
      check({tag, ".busy_cycles"}, 32'(bc), 32'(exp_busy(m, q)));
      check({tag, ".product"}, 32'(product), 32'(exp));
      @(negedge clk);
      check({tag, ".done_once"}, 32'(done), 32'd0);
      check({tag, ".hold"}, 32'(product), 32'(exp));
   endtask

   initial begin
      int bc;
      bit seen;
      bit sm;
      logic [7:0] m, q;

      rst = 1'b1;
      start = 1'b0;
      signed_mode = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check("reset.product", 32'(product), 32'd0);
      rst = 1'b0;

      run_op("s_3x-4", 1'b1, 8'd3, 8'hFC);
      run_op("u_ffxff", 1'b0, 8'hFF, 8'hFF);
      run_op("s_ffxff", 1'b1, 8'hFF, 8'hFF);
      run_op("s_80x80", 1'b1, 8'h80, 8'h80);
      run_op("s_80x7f", 1'b1, 8'h80, 8'h7F);
      run_op("u_80x80", 1'b0, 8'h80, 8'h80);
      run_op("zero", 1'b1, 8'h00, 8'h55);

      // Start during RUN and during DONE must be ignored.
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; multiplicand = 8'd5; multiplier = 8'd6;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
      @(posedge clk);
      wait_done("hs_run", bc, seen, 1'b0);
      check("hs_run.product", 32'(product), 32'h001E);
      start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
      @(negedge clk);
      start = 1'b0;
      check("hs_done.ignored_busy", 32'(busy), 32'd0);
      check("hs_done.product", 32'(product), 32'h001E);
      run_op("hs_next", 1'b0, 8'd9, 8'd9);

      // Reset in the middle of RUN.
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b1; multiplicand = 8'd7; multiplier = 8'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst.busy", 32'(busy), 32'd0);
      check("midrst.done", 32'(done), 32'd0);
      check("midrst.product", 32'(product), 32'd0);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      check("midrst.quiet", 32'(seen), 32'd0);
      run_op("midrst.fresh", 1'b0, 8'd2, 8'd3);

      // Reset and start together: reset wins.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; multiplicand = 8'd4; multiplier = 8'd4;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_start.busy", 32'(busy), 32'd0);

      for (int i = 0; i < 30; i++) begin
         sm = 1'($urandom);
         m = 8'($urandom);
         q = 8'($urandom);
         run_op($sformatf("rnd%0d", i), sm, m, q);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
